// File: rtl/state_ctrl_pkg.sv
// Shared codes for the stage sequencer: state-code width, the reserved idle
// and final stage codes, and the controller FSM encoding.
// No logic lives here; latency/backpressure are defined by the users.
package state_ctrl_pkg;

  // Width of the stage codes exchanged with state_machine.
  localparam int STATE_W = 4;

  // Code that parks state_machine between runs.
  localparam logic [STATE_W-1:0] IDLE_CODE = 4'd0;

  // Default final stage of a run.
  localparam logic [STATE_W-1:0] FINISH_CODE = 4'd3;

  // Width of the controller state register.
  localparam int CTRL_LEN = 3;

  typedef enum logic [CTRL_LEN-1:0] {
    C_IDLE  = 3'd0,
    C_LOAD  = 3'd1,
    C_ISSUE = 3'd2,
    C_WAIT  = 3'd3,
    C_ADV   = 3'd4,
    C_DONE  = 3'd5,
    C_ABORT = 3'd6
  } ctrl_t;

  // A run is in progress in every controller state except idle.
  function automatic logic is_active(input ctrl_t s);
    return s != C_IDLE;
  endfunction

endpackage

// File: rtl/state_ctrl_timer.sv
// Per-stage watchdog: counts cycles spent waiting on the datapath.
// Latency: count updates one cycle after enable; expired is combinational on count.
// Backpressure: none; clear wins over enable, count saturates at TIMEOUT-1.
module stage_timer
  import state_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count;

  // Saturating up-counter; holding at the limit keeps it from ever wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/state_ctrl.sv
// Sequencer driving run/set/d of state_machine: load start stage, wait per stage, advance, reload idle.
// Latency: start at edge N -> set during N+1, stage_start during N+2; stage_done at M -> run M+1, stage_start M+2.
// Backpressure: stall holds the advance step only; abort and stage timeout force an idle reload.
module state_ctrl
  import state_ctrl_pkg::*;
#(
  parameter int                   STATE_LEN  = STATE_W,
  parameter logic [STATE_LEN-1:0] LAST_STATE = STATE_LEN'(FINISH_CODE),
  parameter int                   TIMEOUT    = 1024,
  parameter int                   TO_W       = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [STATE_LEN-1:0] start_state,
  input  logic                 abort,
  input  logic                 stall,
  input  logic                 stage_done,
  input  logic [STATE_LEN-1:0] q,
  output logic                 run,
  output logic                 set,
  output logic [STATE_LEN-1:0] d,
  output logic                 stage_start,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [STATE_LEN-1:0] IDLE_D = STATE_LEN'(IDLE_CODE);

  ctrl_t st;
  logic  tmr_clear;
  logic  tmr_en;
  logic  tmr_expired;

  // The timer restarts as each stage is announced and only runs while waiting.
  assign tmr_clear = (st == C_ISSUE);
  assign tmr_en    = (st == C_WAIT);

  stage_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  // Controller FSM; every output is registered from the state being left,
  // so commands reach state_machine one cycle after the FSM decides them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= C_IDLE;
      run         <= 1'b0;
      set         <= 1'b0;
      d           <= IDLE_D;
      stage_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      run         <= 1'b0;
      set         <= 1'b0;
      stage_start <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      busy        <= is_active(st);
      // Abort cancels whatever this state would have issued; an abort
      // already in progress simply completes.
      if (abort && (st != C_IDLE) && (st != C_ABORT)) begin
        st <= C_ABORT;
      end else begin
        case (st)
          C_IDLE: begin
            if (start) begin
              d  <= start_state;
              st <= C_LOAD;
            end
          end
          C_LOAD: begin
            run <= 1'b1;
            set <= 1'b1;
            st  <= C_ISSUE;
          end
          C_ISSUE: begin
            stage_start <= 1'b1;
            st          <= C_WAIT;
          end
          C_WAIT: begin
            // A completion in the expiry cycle still counts as success.
            if (stage_done) begin
              if (q == LAST_STATE) begin
                st <= C_DONE;
              end else begin
                st <= C_ADV;
              end
            end else if (tmr_expired) begin
              err <= 1'b1;
              st  <= C_ABORT;
            end
          end
          C_ADV: begin
            if (!stall) begin
              run <= 1'b1;
              st  <= C_ISSUE;
            end
          end
          C_DONE: begin
            run  <= 1'b1;
            set  <= 1'b1;
            d    <= IDLE_D;
            done <= 1'b1;
            st   <= C_IDLE;
          end
          C_ABORT: begin
            run <= 1'b1;
            set <= 1'b1;
            d   <= IDLE_D;
            st  <= C_IDLE;
          end
          default: begin
            st <= C_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/state_ctrl.md
Name: state_ctrl

Overview:
- Sequencer that drives the `run`/`set`/`d` command inputs of `state_machine` and consumes its `q` output. It is the initiator side of that interface.
- It loads a start state, waits for the datapath to finish each stage, then advances the state machine. After the last stage, or on timeout/abort, it reloads `IDLE`.
- Sits between the host/top-level start logic, the per-stage compute units, and `state_machine`.

Parameters:
- STATE_LEN, `STATE_LEN (consts_trained.vh): width of state codes.
- LAST_STATE, `FINISH (consts_trained.vh): final stage code; its `stage_done` completes the run.
- TIMEOUT, 1024: maximum cycles allowed in WAIT per stage before an error.
- TO_W, $clog2(TIMEOUT+1): width of the timeout counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin a run at `start_state` (ignored unless idle)
- start_state  in  STATE_LEN  first stage code, sampled with `start`
- abort  in  1  pulse; cancel the current run
- stall  in  1  level; downstream not ready, blocks advancing
- stage_done  in  1  pulse from the datapath: current stage finished
- q  in  STATE_LEN  current state from `state_machine`
- run  out  1  command to `state_machine`
- set  out  1  command to `state_machine`
- d  out  STATE_LEN  load value to `state_machine`
- stage_start  out  1  one-cycle pulse: `q` holds a new stage, datapath may begin
- busy  out  1  high in every FSM state except C_IDLE
- done  out  1  one-cycle pulse when the run completes normally
- err  out  1  one-cycle pulse on stage timeout

Behaviour:
- Reset is asynchronous, active-low: single clock `clk`, reset `rst_n`.
- While `rst_n`=0: FSM=C_IDLE, run=0, set=0, d=`IDLE, stage_start=0, busy=0, done=0, err=0, timer=0.
- `state_machine` contract (decided), applied at each clk edge:
  - run=1, set=1: q<=d.
  - run=1, set=0: q<=next(q).
  - run=0: q holds.
- All outputs are registered. Each FSM state below lists the outputs it drives.
- C_IDLE: run=0, set=0.
  - On `start`: d<=start_state, go to C_LOAD.
- C_LOAD: run=1, set=1 for exactly one cycle, then C_ISSUE.
- C_ISSUE: stage_start=1 for one cycle, timer<=0, then C_WAIT.
- C_WAIT: run=0, timer increments each cycle.
  - `stage_done` and q==LAST_STATE: go to C_DONE.
  - `stage_done` otherwise: go to C_ADV.
  - timer==TIMEOUT-1 with no `stage_done`: err=1 pulse, go to C_ABORT.
- C_ADV: stall=1 holds in C_ADV with run=0. Otherwise run=1, set=0 for one cycle, then C_ISSUE.
- C_DONE: run=1, set=1, d=`IDLE for one cycle; done=1 that cycle; then C_IDLE.
- C_ABORT: run=1, set=1, d=`IDLE for one cycle; then C_IDLE. `done` is not asserted.
- Latency:
  - `start` sampled at edge N: set=1 during cycle N+1, q=start_state after edge N+2, stage_start during cycle N+2.
  - `stage_done` at edge M (not last, no stall): run=1 during cycle M+1, stage_start during cycle M+2.
- Boundary cases:
  - `start` while busy: ignored; start_state is not latched.
  - `abort` in any non-IDLE state: go to C_ABORT next cycle. Abort beats `stage_done` and timeout when simultaneous. `abort` in C_IDLE is ignored.
  - `stage_done` and timeout in the same cycle: `stage_done` wins, no err.
  - `stage_done` outside C_WAIT: ignored, not remembered.
  - start_state==LAST_STATE: a single-stage run, i.e. LOAD, ISSUE, WAIT, DONE.
  - Timer saturates and never wraps; it is cleared on every entry to C_ISSUE.
  - `stall` only has effect in C_ADV.
  - `rst_n` low mid-run: immediate return to reset values; q is reset by `state_machine` itself.

Decomposition:
- consts_trained.vh (shared): `STATE_LEN, `IDLE, `FINISH.
- Add to that header: controller state codes C_IDLE, C_LOAD, C_ISSUE, C_WAIT, C_ADV, C_DONE, C_ABORT, and `CTRL_LEN (3).
- One sub-module: stage_timer (clear, enable, saturating count, `expired` at TIMEOUT-1).

Test Plan (STATE_LEN=4, IDLE=0, LAST_STATE=3, TIMEOUT=8, bench instantiates state_ctrl with state_machine):
- Normal run: start with start_state=1; `stage_done` 3 cycles after each stage_start. Required: q goes 1→2→3→0, 3 stage_start pulses, 1 done pulse, busy falls the cycle after done, err never asserted.
- Stall: `stall`=1 for 5 cycles right after the first `stage_done`. Required: q holds 1 for those 5 cycles with run=0; advances to 2 one cycle after stall drops.
- Timeout: start with start_state=2, no `stage_done`. Required: err pulses 8 cycles after stage_start, q returns to 0, done=0, busy=0.
- Abort vs done collision: `abort` and `stage_done` asserted in the same cycle in stage 2. Required: C_ABORT, q=0, no done, no further stage_start. Also `start` pulsed mid-run is ignored (q sequence unchanged).
- Reset mid-run: drop rst_n while in C_ADV with stall=1. Required: run/set/busy are 0 immediately (asynchronously), d=0. A fresh start after release runs from start_state normally.
- Single stage: start with start_state=3, `stage_done` after 1 cycle. Required: exactly one stage_start, done pulse, q returns 0.
